// File: rtl/xmem_rdport.sv
// Read-side responder for a Versat address generator: a two-stage synchronous
// read pipeline over a host-loadable memory, with run framing and a done pulse.
module xmem_rdport #(
  parameter int unsigned MEM_ADDR_W = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [MEM_ADDR_W-1:0] ag_addr,
  input  logic                  ag_mem_en,
  input  logic                  ag_done,
  input  logic                  wr_en,
  input  logic [MEM_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  rd_done,
  output logic [31:0]           rd_count,
  output logic                  oob_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned CMP_W = MEM_ADDR_W + 1;
  localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] ACTIVE = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] FIN    = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic              drain_cnt;
  logic              drain_cnt_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic              s1_valid;
  logic              s1_oob;
  logic              req_oob;
  logic              wr_ok;
  logic              count_hit;

  assign req_oob   = ag_mem_en && ({1'b0, ag_addr} >= DEPTH_C);
  assign wr_ok     = wr_en && ({1'b0, wr_addr} < DEPTH_C);
  assign count_hit = rd_valid && (state != IDLE);

  // Read-first RAM: the read samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (ag_mem_en && !req_oob) begin
      ram_q <= mem[ag_addr];
    end
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Run sequencing; a run pulse restarts from any state
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    if (run) begin
      state_next     = ARM;
      drain_cnt_next = 1'b0;
    end else begin
      case (state)
        IDLE:   state_next = IDLE;
        ARM:    state_next = ACTIVE;
        ACTIVE: begin
          if (ag_done && !ag_mem_en) begin
            state_next     = DRAIN;
            drain_cnt_next = 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state_next = FIN;
          end else begin
            drain_cnt_next = 1'b1;
          end
        end
        FIN:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      rd_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      rd_done   <= (state_next == FIN);
      busy      <= (state_next != IDLE);
    end
  end

  // Stage-1 flags and stage-2 output register, plus run statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_count <= '0;
      oob_err  <= 1'b0;
    end else begin
      s1_valid <= ag_mem_en;
      s1_oob   <= req_oob;
      rd_valid <= s1_valid;
      rd_data  <= (s1_valid && !s1_oob) ? ram_q : '0;
      if (run) begin
        // Words surfacing in the restart cycle belong to the new run
        rd_count <= count_hit ? CNT_W'(1) : '0;
        oob_err  <= req_oob;
      end else begin
        if (count_hit && (rd_count != '1)) begin
          rd_count <= rd_count + CNT_W'(1);
        end
        oob_err <= oob_err | req_oob;
      end
    end
  end

endmodule

// File: tb/tb_xmem_rdport.sv
// Randomized bench for xmem_rdport against a cycle-stamped expectation model
// built from the block's latency and framing rules.
module tb_xmem_rdport;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [AW-1:0] ag_addr;
  logic          ag_mem_en;
  logic          ag_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_done;
  logic [31:0]   rd_count;
  logic          oob_err;
  logic          busy;

  xmem_rdport #(.MEM_ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .run(run), .ag_addr(ag_addr), .ag_mem_en(ag_mem_en),
    .ag_done(ag_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
    .rd_count(rd_count), .oob_err(oob_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expectations keyed by the cycle in which the output must be visible
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_valid [int];
  int          exp_done [int];
  bit          oob_tab [int];
  bit          oob_m = 1'b0;
  int          bfrom = -1;
  int          dcyc = -1;
  int          run_cyc = 0;
  int          cnt_lo = 0;
  bit          armed = 1'b0;

  function automatic bit model_busy(input int k);
    return (bfrom >= 0) && (k >= bfrom) && ((dcyc < 0) || (k <= dcyc));
  endfunction

  task automatic step(input bit s_run, input bit s_en, input int s_addr, input bit s_done,
                      input bit s_we, input int s_wa, input logic [31:0] s_wd, input bit s_rst);
    int k;
    int n;
    bit roob;
    bit was_busy;
    @(posedge clk);
    #1;
    k = cyc;
    rst = s_rst; run = s_run; ag_mem_en = s_en; ag_addr = AW'(s_addr); ag_done = s_done;
    wr_en = s_we; wr_addr = AW'(s_wa); wr_data = s_wd;
    if (s_rst) begin
      for (int j = k + 1; j <= k + 4; j++) begin
        if (exp_valid.exists(j)) exp_valid.delete(j);
        if (exp_done.exists(j)) exp_done.delete(j);
      end
      if (bfrom > k) bfrom = -1;
      if ((bfrom >= 0) && ((dcyc < 0) || (dcyc > k))) dcyc = k;
      armed = 1'b0;
      oob_m = 1'b0;
    end else begin
      roob = s_en && (s_addr >= int'(DEPTH));
      if (s_en) exp_valid[k+2] = roob ? 32'd0 : mem_m[s_addr];
      oob_m = s_run ? roob : (oob_m | roob);
      if (s_run) begin
        was_busy = model_busy(k);
        for (int j = k + 1; j <= k + 4; j++)
          if (exp_done.exists(j)) exp_done.delete(j);
        if (!was_busy) bfrom = k + 1;
        dcyc = -1;
        run_cyc = k;
        cnt_lo = was_busy ? k : k + 1;
        armed = 1'b1;
      end else if (armed && (k >= run_cyc + 2) && s_done && !s_en) begin
        armed = 1'b0;
        dcyc = k + 3;
        n = 0;
        for (int j = cnt_lo; j <= k + 2; j++)
          if (exp_valid.exists(j)) n++;
        exp_done[k+3] = n;
      end
    end
    oob_tab[k+1] = oob_m;
    if (s_we && (s_wa < int'(DEPTH))) mem_m[s_wa] = s_wd;
  endtask

  task automatic idle(input int n, input bit d);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, d, 1'b0, 0, 32'd0, 1'b0);
  endtask

  task automatic rd(input int a);
    step(1'b0, 1'b1, a, 1'b0, 1'b0, 0, 32'd0, 1'b0);
  endtask

  task automatic start(input bit arm_done);
    step(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 0, arm_done, 1'b0, 0, 32'd0, 1'b0);
  endtask

  bit ev;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      ev = exp_valid.exists(cyc);
      check("rd_valid", 32'(rd_valid), 32'(ev));
      if (ev) check("rd_data", rd_data, exp_valid[cyc]);
      check("rd_done", 32'(rd_done), 32'(exp_done.exists(cyc)));
      if (exp_done.exists(cyc)) check("rd_count_done", rd_count, 32'(exp_done[cyc]));
      if (oob_tab.exists(cyc)) check("oob_err", 32'(oob_err), 32'(oob_tab[cyc]));
      check("busy", 32'(busy), 32'(model_busy(cyc)));
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; ag_addr = '0; ag_mem_en = 1'b0; ag_done = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    oob_tab[1] = 1'b0;
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'd0, 1'b1);
    idle(2, 1'b0);
    @(negedge clk);
    check("reset_count", rd_count, 32'd0);
    check("reset_data", rd_data, 32'd0);

    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b0, 1'b0, 0, 1'b1, 1'b1, i, 32'(i + 100), 1'b0);

    // Sequential stream 0..7 with stale done masked by the arm cycle
    start(1'b1);
    for (int a = 0; a < 8; a++) rd(a);
    idle(6, 1'b1);

    // Collision: host write and stream read to the same word
    start(1'b0);
    rd(4);
    step(1'b0, 1'b1, 5, 1'b0, 1'b1, 5, 32'h0000_AAAA, 1'b0);
    rd(5);
    idle(6, 1'b1);

    // Out-of-range reads around the implemented depth
    start(1'b0);
    rd(998); rd(999); rd(1000); rd(1023);
    idle(6, 1'b1);

    // Stray request while idle: data returned, count untouched
    step(1'b0, 1'b1, 7, 1'b1, 1'b0, 0, 32'd0, 1'b0);
    idle(4, 1'b1);
    @(negedge clk);
    check("idle_count_hold", rd_count, 32'd4);

    // Zero-iteration run
    start(1'b1);
    idle(6, 1'b1);

    // Restart after three reads
    start(1'b0);
    rd(0); rd(1); rd(2);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    for (int a = 0; a < 8; a++) rd(a + 10);
    idle(6, 1'b1);

    // Reset two cycles after a request
    start(1'b0);
    rd(3); rd(4);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'd0, 1'b1);
    idle(3, 1'b0);
    @(negedge clk);
    check("rst_mid_count", rd_count, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);

    // Random runs with concurrent host writes and occasional bad addresses
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(0, 10);
      start(1'($urandom_range(0, 1)));
      for (int q = 0; q < n; q++) begin
        int gap;
        int a;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++)
          step(1'b0, 1'b0, 0, 1'b0, 1'($urandom_range(0, 2) == 0),
               $urandom_range(0, 1023), $urandom, 1'b0);
        a = ($urandom_range(0, 4) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 999);
        step(1'b0, 1'b1, a, 1'b0, 1'($urandom_range(0, 2) == 0),
             $urandom_range(0, 1023), $urandom, 1'b0);
      end
      for (int g = 0; g < $urandom_range(5, 8); g++)
        step(1'b0, 1'b0, 0, 1'b1, 1'($urandom_range(0, 2) == 0),
             $urandom_range(0, 1023), $urandom, 1'b0);
    end

    idle(5, 1'b1);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
